// File: rtl/mem_branch_resolver.sv
// MEM-stage branch resolver: owns the architectural NZP condition codes,
// resolves BR/JMP/JSR/TRAP against the fetch-time prediction, issues a
// one-cycle flush/redirect on mispredicts, squashes the wrong-path
// instruction behind it, and emits predictor updates and saturating counters.
module mem_branch_resolver #(
  parameter int width     = 16,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_valid,
  input  logic                 mem_stall,
  input  logic                 is_br,
  input  logic                 is_jump,
  input  logic [2:0]           br_nzp,
  input  logic                 predicted_taken,
  input  logic                 predictor_sel,
  input  logic [width-1:0]     btb_target,
  input  logic [width-1:0]     flush_pc,
  input  logic [width-1:0]     target_pc,
  input  logic [width-1:0]     pc,
  input  logic                 cc_load,
  input  logic [width-1:0]     cc_value,
  output logic [2:0]           nzp,
  output logic                 flush,
  output logic [width-1:0]     redirect_pc,
  output logic                 mem_squash,
  output logic                 bp_update_valid,
  output logic [width-1:0]     bp_update_pc,
  output logic                 bp_update_taken,
  output logic [width-1:0]     bp_update_target,
  output logic                 bp_update_sel,
  output logic [cnt_width-1:0] branch_count,
  output logic [cnt_width-1:0] mispredict_count
);

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic is_ctrl;
  logic taken;
  logic mispredict;
  logic resolve;
  logic [2:0] cc_next;

  // The wrong-path slot is blocked while flushing; branches read the CC
  // produced by older instructions, i.e. the registered nzp.
  assign accept     = mem_valid & ~mem_stall & (state == RUN);
  assign is_ctrl    = is_br | is_jump;
  assign taken      = is_jump | (is_br & (|(br_nzp & nzp)));
  assign mispredict = is_ctrl & ((taken != predicted_taken) |
                                 (taken & predicted_taken & (btb_target != target_pc)));
  assign resolve    = accept & is_ctrl;

  // The FLUSH cycle is both the fetch redirect and the squash of MEM.
  assign flush      = (state == FLUSH);
  assign mem_squash = (state == FLUSH);

  // Decode a data word into a one-hot N/Z/P code.
  always_comb begin
    cc_next = 3'b001;
    if (cc_value[width-1])
      cc_next = 3'b100;
    else if (cc_value == '0)
      cc_next = 3'b010;
  end

  // Next-state logic: a mispredicted resolution costs exactly one FLUSH cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (resolve && mispredict) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= RUN;
    else
      state <= state_next;
  end

  // Architectural condition-code register.
  always_ff @(posedge clk) begin
    if (!reset_n)
      nzp <= 3'b010;
    else if (accept && cc_load)
      nzp <= cc_next;
  end

  // Redirect target and predictor update; the valid bit is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      redirect_pc      <= '0;
      bp_update_valid  <= 1'b0;
      bp_update_pc     <= '0;
      bp_update_taken  <= 1'b0;
      bp_update_target <= '0;
      bp_update_sel    <= 1'b0;
    end else begin
      bp_update_valid <= resolve;
      if (resolve) begin
        bp_update_pc     <= pc;
        bp_update_taken  <= taken;
        bp_update_target <= target_pc;
        bp_update_sel    <= predictor_sel;
        if (mispredict)
          redirect_pc <= taken ? target_pc : flush_pc;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve) begin
      if (!(&branch_count))
        branch_count <= branch_count + cnt_width'(1);
      if (mispredict && !(&mispredict_count))
        mispredict_count <= mispredict_count + cnt_width'(1);
    end
  end

endmodule

// File: tb/tb_mem_branch_resolver.sv
// Scoreboard bench for mem_branch_resolver: a driver issues directed and
// random instructions, a spec-level model pushes expected per-cycle state and
// predictor updates into queues, and a monitor pops and compares them.
module tb_mem_branch_resolver;

  localparam int W = 16;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_valid, mem_stall, is_br, is_jump;
  logic [2:0] br_nzp;
  logic predicted_taken, predictor_sel;
  logic [W-1:0] btb_target, flush_pc, target_pc, pc;
  logic cc_load;
  logic [W-1:0] cc_value;
  logic [2:0] nzp;
  logic flush, mem_squash, bp_update_valid, bp_update_taken, bp_update_sel;
  logic [W-1:0] redirect_pc, bp_update_pc, bp_update_target;
  logic [C-1:0] branch_count, mispredict_count;

  mem_branch_resolver #(.width(W), .cnt_width(C)) dut (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .is_br(is_br), .is_jump(is_jump), .br_nzp(br_nzp),
    .predicted_taken(predicted_taken), .predictor_sel(predictor_sel),
    .btb_target(btb_target), .flush_pc(flush_pc), .target_pc(target_pc),
    .pc(pc), .cc_load(cc_load), .cc_value(cc_value), .nzp(nzp),
    .flush(flush), .redirect_pc(redirect_pc), .mem_squash(mem_squash),
    .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
    .bp_update_taken(bp_update_taken), .bp_update_target(bp_update_target),
    .bp_update_sel(bp_update_sel), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, valid, stall, br, jmp;
    logic [2:0] bnzp;
    logic pt, sel;
    logic [W-1:0] btb, fpc, tpc, ipc;
    logic ccl;
    logic [W-1:0] ccv;
  } stim_t;

  typedef struct {
    logic [2:0] nzp;
    logic fl, bpv;
    logic [C-1:0] bc, mc;
    logic [W-1:0] rpc;
  } cyc_t;

  typedef struct {
    logic [W-1:0] ipc, tgt;
    logic tk, sel;
  } res_t;

  cyc_t cyc_q[$];
  res_t res_q[$];

  int checks = 0;
  int errors = 0;

  // Model state: CC, "next cycle is the squash cycle", and counters.
  logic [2:0] m_nzp = 3'b010;
  logic m_flush = 1'b0;
  int m_bc = 0;
  int m_mc = 0;
  localparam int CMAX = (1 << C) - 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, valid: 1'b0, stall: 1'b0, br: 1'b0, jmp: 1'b0, bnzp: 3'b000,
          pt: 1'b0, sel: 1'b0, btb: '0, fpc: '0, tpc: '0, ipc: '0, ccl: 1'b0, ccv: '0};
    return s;
  endfunction

  // Drive one cycle of inputs, predict its effect from the architectural rules
  // and queue the expectation for the monitor.
  task automatic applyStimulus(input stim_t s);
    cyc_t e;
    res_t r;
    logic acc, ctrl, tk, mis, res;
    reset_n = s.rst_n; mem_valid = s.valid; mem_stall = s.stall;
    is_br = s.br; is_jump = s.jmp; br_nzp = s.bnzp;
    predicted_taken = s.pt; predictor_sel = s.sel;
    btb_target = s.btb; flush_pc = s.fpc; target_pc = s.tpc; pc = s.ipc;
    cc_load = s.ccl; cc_value = s.ccv;
    e.rpc = '0;
    if (!s.rst_n) begin
      m_nzp = 3'b010; m_flush = 1'b0; m_bc = 0; m_mc = 0;
      e.bpv = 1'b0;
    end else begin
      acc  = s.valid && !s.stall && !m_flush;
      ctrl = s.br || s.jmp;
      tk   = s.jmp || (s.br && ((s.bnzp & m_nzp) != 3'b000));
      mis  = ctrl && ((tk != s.pt) || (tk && s.pt && (s.btb != s.tpc)));
      res  = acc && ctrl;
      if (res) begin
        m_bc = (m_bc == CMAX) ? CMAX : m_bc + 1;
        if (mis) m_mc = (m_mc == CMAX) ? CMAX : m_mc + 1;
        r.ipc = s.ipc; r.tgt = s.tpc; r.tk = tk; r.sel = s.sel;
        res_q.push_back(r);
        e.rpc = tk ? s.tpc : s.fpc;
      end
      if (acc && s.ccl)
        m_nzp = ($signed(s.ccv) < 0) ? 3'b100 : (s.ccv == '0) ? 3'b010 : 3'b001;
      m_flush = res && mis;
      e.bpv = res;
    end
    e.nzp = m_nzp; e.fl = m_flush; e.bc = C'(m_bc); e.mc = C'(m_mc);
    cyc_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare registered outputs just after each active edge.
  initial begin
    cyc_t e;
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() == 0) begin
        checkOutput("cycle_expectation_present", 32'(0), 32'(1));
      end else begin
        e = cyc_q.pop_front();
        checkOutput("nzp", 32'(nzp), 32'(e.nzp));
        checkOutput("flush", 32'(flush), 32'(e.fl));
        checkOutput("mem_squash", 32'(mem_squash), 32'(e.fl));
        checkOutput("bp_update_valid", 32'(bp_update_valid), 32'(e.bpv));
        checkOutput("branch_count", 32'(branch_count), 32'(e.bc));
        checkOutput("mispredict_count", 32'(mispredict_count), 32'(e.mc));
        if (e.fl) checkOutput("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
      end
      if (bp_update_valid === 1'b1) begin
        if (res_q.size() == 0) begin
          checkOutput("update_expected", 32'(0), 32'(1));
        end else begin
          r = res_q.pop_front();
          checkOutput("bp_update_pc", 32'(bp_update_pc), 32'(r.ipc));
          checkOutput("bp_update_taken", 32'(bp_update_taken), 32'(r.tk));
          checkOutput("bp_update_target", 32'(bp_update_target), 32'(r.tgt));
          checkOutput("bp_update_sel", 32'(bp_update_sel), 32'(r.sel));
        end
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    stim_t s;
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    // Negative value sets N.
    s = idle(); s.valid = 1'b1; s.ccl = 1'b1; s.ccv = 16'h8000;
    applyStimulus(s);
    // Zero sets Z, then correctly predicted BRz.
    s.ccv = 16'h0000;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.br = 1'b1; s.bnzp = 3'b010; s.pt = 1'b1;
    s.btb = 16'h3000; s.tpc = 16'h3000; s.ipc = 16'h2ffe; s.sel = 1'b1;
    applyStimulus(s);
    // Positive CC, BRn predicted taken -> not taken, redirect to fall-through.
    s = idle(); s.valid = 1'b1; s.ccl = 1'b1; s.ccv = 16'h0005;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.br = 1'b1; s.bnzp = 3'b100; s.pt = 1'b1;
    s.btb = 16'h2000; s.tpc = 16'h2000; s.fpc = 16'h1236; s.ipc = 16'h1234;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.ccl = 1'b1; s.ccv = 16'h0000;
    applyStimulus(s);
    applyStimulus(idle());
    // JMP with a stale BTB target.
    s = idle(); s.valid = 1'b1; s.jmp = 1'b1; s.pt = 1'b1;
    s.btb = 16'h4000; s.tpc = 16'h5000; s.ipc = 16'h1300;
    applyStimulus(s);
    applyStimulus(idle());
    // Mispredicted BR held by a 3-cycle stall.
    s = idle(); s.valid = 1'b1; s.br = 1'b1; s.bnzp = 3'b111; s.pt = 1'b0;
    s.tpc = 16'h6000; s.fpc = 16'h1402; s.ipc = 16'h1400; s.stall = 1'b1;
    repeat (3) applyStimulus(s);
    s.stall = 1'b0;
    applyStimulus(s);
    applyStimulus(idle());
    // Back-to-back correct branches, then enough mispredicts to saturate.
    s = idle(); s.valid = 1'b1; s.jmp = 1'b1; s.pt = 1'b1; s.btb = 16'h7000; s.tpc = 16'h7000;
    repeat (3) applyStimulus(s);
    s.pt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s.ipc = 16'(i * 2);
      applyStimulus(s);
      applyStimulus(idle());
    end
    // Reset asserted during the FLUSH cycle.
    applyStimulus(s);
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int kind;
      s = idle();
      s.rst_n = ($urandom % 300) != 0;
      s.valid = ($urandom % 10) < 8;
      s.stall = ($urandom % 5) == 0;
      kind = $urandom % 3;
      s.br = (kind == 1);
      s.jmp = (kind == 2);
      s.bnzp = 3'($urandom_range(1, 7));
      s.pt = 1'($urandom);
      s.sel = 1'($urandom);
      s.tpc = 16'($urandom) & 16'hfffe;
      s.btb = ($urandom % 2) ? s.tpc : (16'($urandom) & 16'hfffe);
      s.ipc = 16'($urandom) & 16'hfffe;
      s.fpc = s.ipc + 16'd2;
      s.ccl = ($urandom % 3) == 0;
      case ($urandom % 4)
        0: s.ccv = 16'h0000;
        1: s.ccv = 16'h8000;
        default: s.ccv = 16'($urandom);
      endcase
      applyStimulus(s);
    end
    repeat (3) applyStimulus(idle());

    checkOutput("cycle_queue_drained", 32'(cyc_q.size()), 32'(0));
    checkOutput("update_queue_drained", 32'(res_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_branch_resolver.md
Name: mem_branch_resolver

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: owns the architectural NZP condition-code register and resolves BR/JMP/JSR/TRAP against the fetch-time prediction.
- On a misprediction it issues a one-cycle flush and redirect PC to fetch and the upstream stage registers, and squashes the wrong-path instruction that enters MEM behind it.
- Emits predictor/BTB update pulses and saturating branch/mispredict counters.

Parameters:
- width, 16, PC and data word width
- cnt_width, 16, width of the performance counters

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- mem_valid  in  1  EX/MEM holds a real instruction (inverse of its is_nop flag)
- mem_stall  in  1  MEM stage is stalled; no state update while high
- is_br  in  1  conditional BR in MEM
- is_jump  in  1  unconditional control transfer (JMP/JSR/TRAP) in MEM
- br_nzp  in  3  IR nzp field of the BR
- predicted_taken  in  1  fetch-time prediction carried through the pipeline
- predictor_sel  in  1  predictor-select bit carried through the pipeline
- btb_target  in  width  BTB target used at fetch
- flush_pc  in  width  fall-through PC (PC+2)
- target_pc  in  width  resolved target (PC adder / jump register)
- pc  in  width  PC of the instruction in MEM
- cc_load  in  1  instruction in MEM writes CC
- cc_value  in  width  value setting CC
- nzp  out  3  architectural CC register
- flush  out  1  one-cycle flush of IF/ID and ID/EX, and fetch redirect
- redirect_pc  out  width  fetch PC, valid while flush=1
- mem_squash  out  1  suppress dcache/regfile/CC side effects of the instruction in MEM
- bp_update_valid  out  1  one-cycle predictor/BTB update
- bp_update_pc  out  width  PC of the resolved branch
- bp_update_taken  out  1  actual outcome
- bp_update_target  out  width  actual target
- bp_update_sel  out  1  predictor_sel of the resolved branch
- branch_count  out  cnt_width  resolved control transfers
- mispredict_count  out  cnt_width  mispredictions

Behaviour:
- Reset values: nzp=3'b010; flush, mem_squash, and bp_update_valid are 0; redirect_pc and all bp_update_* fields are 0; both counters are 0; FSM is in RUN.
- Accept condition: accept = mem_valid & ~mem_stall & (state==RUN).
- CC update: when accept & cc_load, the register loads at the next edge.
  - n = cc_value[width-1]
  - z = (cc_value==0)
  - p = ~n & ~z
  - Exactly one bit of nzp is ever set.
- Outcome: taken = is_jump | (is_br & |(br_nzp & nzp)).
  - The branch uses the registered nzp, i.e. the CC produced by older instructions.
- Misprediction: mispredict = (is_br|is_jump) & ((taken != predicted_taken) | (taken & predicted_taken & (btb_target != target_pc))).
- Resolution (on accept & (is_br|is_jump)):
  - The registers take their values at edge t+1 and hold them for exactly one cycle.
  - bp_update_valid=1, bp_update_pc=pc, bp_update_taken=taken, bp_update_target=target_pc, bp_update_sel=predictor_sel.
  - branch_count increments, saturating at all-ones.
  - If mispredict: flush=1, redirect_pc = taken ? target_pc : flush_pc, mispredict_count increments (saturating), and the FSM goes to FLUSH.
- FSM states:
  - RUN: normal operation. RUN to FLUSH on a mispredicted accept.
  - FLUSH: lasts one cycle. flush=1 and mem_squash=1. The instruction in MEM is wrong-path, so its CC load and branch resolution are ignored. Returns to RUN unconditionally, even if mem_stall=1.
- Stall: while mem_stall=1 in RUN, nothing updates and pulses are not repeated; the held branch resolves once, on the first unstalled cycle.
- Back-to-back branches: the next accept can happen in the cycle after FLUSH.
  - Correctly predicted branches may resolve on consecutive cycles, producing consecutive bp_update pulses.
- mem_valid=0 (bubble or flushed slot): no effect.
- Reset mid-FLUSH: flush, mem_squash, and bp_update_valid drop at the reset edge; the FSM enters RUN; nzp returns to 3'b010.

Test Plan:
- Reset, then idle -> nzp=010, flush=0, counters=0; cc_load with cc_value=0x8000 -> nzp=100 next cycle.
- CC=Z, BRz predicted taken, btb_target=target_pc=0x3000 -> bp_update_valid pulse with taken=1; flush stays 0; branch_count=1, mispredict_count=0.
- CC=P, BRn predicted taken, flush_pc=0x1236 -> flush=1 for one cycle with redirect_pc=0x1236; the next MEM instruction, with cc_load and cc_value=0, gets mem_squash=1 and nzp stays 001; mispredict_count=1.
- JMP predicted taken, btb_target=0x4000, target_pc=0x5000 -> flush=1 with redirect_pc=0x5000 and bp_update_target=0x5000.
- Mispredicted BR held for 3 cycles of mem_stall=1 -> exactly one flush and one bp_update, both after the stall releases; branch_count increments once.
- Preload mispredict_count=0xFFFF by forcing, then a mispredict -> stays 0xFFFF; reset_n=0 asserted during FLUSH -> flush=0 and state RUN next cycle.
